timer_counter: RTL



---
 rtl/timer_counter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer with one-shot / auto-reload modes and a level interrupt.
// Define TC_PRESCALE_EN to add the PRESCALE register at offset 0xC and the CNT-rate divider.
module timer_counter #(
    parameter int PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CNT,
        INT
    } state_t;

    state_t                  state;
    logic [3:0]              ctrl;
    logic [31:0]             preset;
    logic [31:0]             count;
    logic                    irq_flag;
    logic [PRESCALE_W-1:0]   prescale;
    logic                    tick;
    logic [1:0]              sel;
    logic                    ctrl_wr;
    logic                    preset_wr;
    logic                    auto_reload;
    logic                    unused_addr_bits;

    assign sel              = addr[3:2];
    assign ctrl_wr          = we && (sel == 2'd0) && byteen[0];
    assign preset_wr        = we && (sel == 2'd1);
    assign auto_reload      = (ctrl[2:1] == 2'b01);
    assign irq              = irq_flag & ctrl[3];
    assign unused_addr_bits = ^{addr[31:4], addr[1:0]};

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
        end
        return res;
    endfunction

`ifdef TC_PRESCALE_EN
    logic [PRESCALE_W-1:0] div;
    logic                  prescale_wr;

    assign prescale_wr = we && (sel == 2'd3);
    assign tick        = (div == prescale);

    // Divider only advances while counting; LOAD restarts it so the first tick is a full period away.
    always_ff @(posedge clk) begin
        if (reset) begin
            div      <= '0;
            prescale <= '0;
        end else begin
            if (state == LOAD) begin
                div <= '0;
            end else if (state == CNT && ctrl[0]) begin
                div <= tick ? '0 : div + 1'b1;
            end
            if (prescale_wr) begin
                prescale <= PRESCALE_W'(merge_lanes(32'(prescale), wdata, byteen));
            end
        end
    end
`else
    assign prescale = '0;
    assign tick     = 1'b1;
`endif

    // FSM first, then bus writes, so a CTRL write overrides the one-shot EN auto-clear
    // while the CNT exit still sees the EN value from before the write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ctrl     <= '0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ctrl[0]) state <= LOAD;
                end
                LOAD: begin
                    count <= preset;
                    state <= CNT;
                end
                CNT: begin
                    if (!ctrl[0]) begin
                        state <= IDLE;
                    end else if (tick) begin
                        if (count > 32'd1) begin
                            count <= count - 32'd1;
                        end else begin
                            count    <= '0;
                            irq_flag <= 1'b1;
                            state    <= INT;
                        end
                    end
                end
                INT: begin
                    state <= IDLE;
                    if (auto_reload) irq_flag <= 1'b0;
                    else             ctrl[0]  <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            if (ctrl_wr) begin
                ctrl     <= wdata[3:0];
                irq_flag <= 1'b0;
            end
            if (preset_wr) begin
                preset <= merge_lanes(preset, wdata, byteen);
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (sel)
            2'd0: rdata = {28'd0, ctrl};
            2'd1: rdata = preset;
            2'd2: rdata = count;
            2'd3: rdata = 32'(prescale);
            default: rdata = '0;
        endcase
    end

endmodule
